// File: rtl/map072_speech_seq.sv
// rtl/map072_speech_seq.sv - mapper 72/92 speech sample sequencer (header fetch + fixed-rate PCM playback)

module map072_speech_seq #(
    parameter int ROM_AW   = 16,
    parameter int RATE_DIV = 6250
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              map_en,
    input  logic              bus_we,
    input  logic [7:0]        bus_data,
    output logic              rom_req,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic              rom_ack,
    input  logic [7:0]        rom_data,
    output logic [7:0]        pcm_out,
    output logic              busy
);

    localparam int CNT_W = $clog2(RATE_DIV);

    // HDRn encodings equal n so the header byte offset is state[1:0]
    typedef enum logic [2:0] {
        HDR0  = 3'd0,
        HDR1  = 3'd1,
        HDR2  = 3'd2,
        HDR3  = 3'd3,
        IDLE  = 3'd4,
        PLAY  = 3'd5,
        DRAIN = 3'd6
    } state_t;

    state_t            state, state_n;
    logic              prev_start, restart_pend, tick_pend;
    logic [3:0]        idx;
    logic [15:0]       hdr_start;
    logic [7:0]        len_hi;
    logic [15:0]       rem;
    logic [ROM_AW-1:0] cur;
    logic [CNT_W-1:0]  rate_cnt;
    logic              cmd_wr, cmd_abort, cmd_start, kill, req_done, rate_tc, hdr_len_zero;
    logic              issue;
    logic [ROM_AW-1:0] issue_addr;

    function automatic logic [ROM_AW-1:0] hdr_addr(input logic [3:0] i, input logic [1:0] n);
        return ROM_AW'({i, n});
    endfunction

    assign cmd_wr       = bus_we & map_en;
    assign cmd_abort    = cmd_wr & bus_data[4];
    assign cmd_start    = cmd_wr & ~bus_data[4] & bus_data[5] & ~prev_start;
    assign kill         = cmd_abort | (cmd_start & (state != IDLE));
    assign req_done     = rom_req & rom_ack;
    assign rate_tc      = (rate_cnt == CNT_W'(RATE_DIV - 1));
    assign hdr_len_zero = ({len_hi, rom_data} == 16'h0000);
    assign busy         = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n    = state;
        issue      = 1'b0;
        issue_addr = cur;
        if (kill) begin
            // an outstanding request is never withdrawn; wait it out in DRAIN
            if (rom_req && !rom_ack) begin
                state_n = DRAIN;
            end else if (cmd_start) begin
                state_n    = HDR0;
                issue      = ~rom_req;
                issue_addr = hdr_addr(bus_data[3:0], 2'd0);
            end else begin
                state_n = IDLE;
            end
        end else if (cmd_start) begin
            state_n    = HDR0;
            issue      = 1'b1;
            issue_addr = hdr_addr(bus_data[3:0], 2'd0);
        end else begin
            case (state)
                HDR0, HDR1, HDR2, HDR3: begin
                    if (!rom_req) begin
                        issue      = 1'b1;
                        issue_addr = hdr_addr(idx, state[1:0]);
                    end else if (rom_ack) begin
                        case (state)
                            HDR0:    state_n = HDR1;
                            HDR1:    state_n = HDR2;
                            HDR2:    state_n = HDR3;
                            default: state_n = hdr_len_zero ? IDLE : PLAY;
                        endcase
                    end
                end
                PLAY: begin
                    // rem==0 is the hold period of the final sample
                    if (rem == 16'd0) begin
                        if (rate_tc) state_n = IDLE;
                    end else if (tick_pend && !rom_req) begin
                        issue      = 1'b1;
                        issue_addr = cur;
                    end
                end
                DRAIN: begin
                    if (rom_ack) state_n = restart_pend ? HDR0 : IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_start   <= 1'b0;
            restart_pend <= 1'b0;
            tick_pend    <= 1'b0;
            idx          <= 4'd0;
            hdr_start    <= 16'd0;
            len_hi       <= 8'd0;
            rem          <= 16'd0;
            cur          <= '0;
            rate_cnt     <= '0;
            rom_req      <= 1'b0;
            rom_addr     <= '0;
            pcm_out      <= 8'h80;
        end else begin
            if (cmd_wr)    prev_start <= bus_data[5];
            if (cmd_start) idx        <= bus_data[3:0];
            restart_pend <= (state_n == DRAIN) && (cmd_start || (restart_pend && !cmd_abort));

            if (issue) begin
                rom_req  <= 1'b1;
                rom_addr <= issue_addr;
            end else if (req_done) begin
                rom_req  <= 1'b0;
            end

            if (req_done && !kill) begin
                case (state)
                    HDR0: hdr_start[15:8] <= rom_data;
                    HDR1: hdr_start[7:0]  <= rom_data;
                    HDR2: len_hi          <= rom_data;
                    HDR3: begin
                        if (!hdr_len_zero) begin
                            cur <= ROM_AW'(hdr_start);
                            rem <= {len_hi, rom_data};
                        end
                    end
                    PLAY: begin
                        cur <= cur + 1'b1;
                        rem <= rem - 16'd1;
                    end
                    default: ;
                endcase
            end

            if (kill)                             pcm_out <= 8'h80;
            else if (state == PLAY && req_done)   pcm_out <= rom_data;
            else if (state_n == IDLE)             pcm_out <= 8'h80;

            if (state != PLAY || kill || (req_done && rem == 16'd1) || rate_tc)
                rate_cnt <= '0;
            else
                rate_cnt <= rate_cnt + 1'b1;

            if (state != PLAY || kill || (req_done && rem == 16'd1))
                tick_pend <= 1'b0;
            else if (rate_tc && rem != 16'd0)
                tick_pend <= 1'b1;
            else if (issue)
                tick_pend <= 1'b0;
        end
    end

endmodule
